bmi_stats: RTL

Downstream consumer of the combinational BMI stage: accepts each 8-bit integer BMI result over a valid/ready handshake, classifies it into one of four health bands, and presents the class code over a second handshake. It also keeps per-band saturating counters, a total counter and running min/max for the session. It sits between the BMI calculator and the display/reporting logic.

---
 rtl/bmi_stats.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/bmi_stats.sv
// bmi_stats: classifies 8-bit integer BMI samples into four health bands and
// keeps session statistics.
//
// A sample is accepted on the bmi_valid/bmi_ready handshake. It is classified
// in the following cycle, and the result is then held on cls_valid/cls_ready
// until the consumer takes it.
//
// Ports:
//   clk        rising-edge clock
//   nrst       synchronous active-low reset
//   bmi_valid  upstream has a sample
//   bmi_in     unsigned BMI value (0 = upstream invalid)
//   bmi_ready  block can accept a sample (driven only by the FSM state)
//   cls_valid  class result available
//   cls_code   band 0..3
//   cls_err    sample was 0; cls_code forced to 0
//   cls_ready  downstream takes the result
//   clear      synchronous clear of all statistics
//   cnt_sel    selects the band counter shown on cnt_out
//   cnt_out    selected band count (combinational mux of registers)
//   total_out  count of all non-error samples
//   min_bmi    smallest non-error BMI seen (8'hFF when none)
//   max_bmi    largest non-error BMI seen (8'h00 when none)
module bmi_stats #(
  parameter int unsigned TH_UNDER  = 18,
  parameter int unsigned TH_NORMAL = 25,
  parameter int unsigned TH_OVER   = 30,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             bmi_valid,
  input  logic [7:0]       bmi_in,
  output logic             bmi_ready,
  output logic             cls_valid,
  output logic [1:0]       cls_code,
  output logic             cls_err,
  input  logic             cls_ready,
  input  logic             clear,
  input  logic [1:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_out,
  output logic [CNT_W-1:0] total_out,
  output logic [7:0]       min_bmi,
  output logic [7:0]       max_bmi
);

  localparam logic [7:0]       TH_U8   = 8'(TH_UNDER);
  localparam logic [7:0]       TH_N8   = 8'(TH_NORMAL);
  localparam logic [7:0]       TH_O8   = 8'(TH_OVER);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLASSIFY = 2'd1,
    PRESENT  = 2'd2
  } state_t;

  state_t           state;
  logic [7:0]       bmi_q;
  logic [1:0]       band_c;
  logic             zero_c;
  logic [CNT_W-1:0] band_cnt [4];

  // Band lookup for the captured sample; thresholds are inclusive on the lower edge.
  always_comb begin
    band_c = 2'd3;
    if (bmi_q < TH_U8) begin
      band_c = 2'd0;
    end else if (bmi_q < TH_N8) begin
      band_c = 2'd1;
    end else if (bmi_q < TH_O8) begin
      band_c = 2'd2;
    end
  end

  assign zero_c = (bmi_q == 8'd0);

  // Handshake FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= IDLE;
      bmi_q     <= 8'd0;
      bmi_ready <= 1'b1;
      cls_valid <= 1'b0;
      cls_code  <= 2'd0;
      cls_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bmi_valid) begin
            bmi_q     <= bmi_in;
            bmi_ready <= 1'b0;
            state     <= CLASSIFY;
          end
        end
        CLASSIFY: begin
          cls_code  <= zero_c ? 2'd0 : band_c;
          cls_err   <= zero_c;
          cls_valid <= 1'b1;
          state     <= PRESENT;
        end
        PRESENT: begin
          if (cls_ready) begin
            cls_valid <= 1'b0;
            bmi_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          cls_valid <= 1'b0;
          bmi_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Statistics; clear beats a coincident classification update.
  always_ff @(posedge clk) begin
    if (!nrst || clear) begin
      for (int i = 0; i < 4; i++) begin
        band_cnt[i] <= '0;
      end
      total_out <= '0;
      min_bmi   <= 8'hFF;
      max_bmi   <= 8'h00;
    end else if (state == CLASSIFY && !zero_c) begin
      if (band_cnt[band_c] != CNT_MAX) begin
        band_cnt[band_c] <= band_cnt[band_c] + CNT_W'(1);
      end
      if (total_out != CNT_MAX) begin
        total_out <= total_out + CNT_W'(1);
      end
      if (bmi_q < min_bmi) begin
        min_bmi <= bmi_q;
      end
      if (bmi_q > max_bmi) begin
        max_bmi <= bmi_q;
      end
    end
  end

  assign cnt_out = band_cnt[cnt_sel];

endmodule
